float_adder_arbiter: RTL
========================

# float_adder_arbiter

Round-robin scheduler that shares one fully pipelined floating-point adder (3 register stages, one operation accepted per cycle, no stall) between N requesters. Each requester presents an operand pair with a valid/ready handshake. The block issues the winning pair to the adder and tracks the owner of every in-flight operation in a tag pipeline, so each result returns as a one-cycle pulse to the requester that launched it. It sits between compute clients and the adder instance at the arithmetic-cluster top level.

## Interface
- `N_REQ`, 4: number of requesters (2..16).
- `E_BIT`, 8: exponent width.
- `F_BIT`, 23: fraction width; the word width is W = E_BIT+F_BIT+1.
- `ADD_LAT`, 3: adder register depth (cycles from adder input sampled to adder_out valid).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester operation pending.
- `req_ready`  out  N_REQ  per-requester grant; a handshake is valid&ready in the same cycle.
- `req_a`  in  N_REQ*W  operand A, requester i at bits [i*W +: W].
- `req_b`  in  N_REQ*W  operand B, same packing.
- `req_sub`  in  N_REQ  subtract request; present only with FADD_ARB_SUB_EN.
- `add_a`, `add_b`  out  W  registered operands to the adder.
- `add_out`  in  W  adder result.
- `rsp_valid`  out  N_REQ  one-hot result pulse; at most one bit set.
- `rsp_data`  out  W  result word, valid only while some rsp_valid bit is set.
- `inflight`  out  clog2(ADD_LAT+2)  number of issued operations whose result has not yet returned.
- `busy`  out  1  inflight != 0.

## Operation
- Arbitration is combinational and round-robin.
  - Pointer `rr_ptr` (clog2(N_REQ) bits) names the highest-priority requester.
  - The first asserted req_valid at or after rr_ptr, with wrap-around, receives req_ready. All other ready bits are 0.
  - If no req_valid is asserted, all req_ready bits are 0 and rr_ptr holds.
- On a handshake by requester g:
  - rr_ptr <= (g+1) mod N_REQ, wrapping from N_REQ-1 to 0.
  - add_a <= req_a[g] and add_b <= req_b[g].
  - An issue tag {1, g} enters the tag pipeline.
- Without a handshake, add_a and add_b hold their previous values and a bubble tag {0, x} enters the pipeline.
- Tag pipeline:
  - ADD_LAT+1 stages, with the stage-0 tag registered alongside add_a and add_b.
  - The tag at depth ADD_LAT drives rsp_valid = valid ? onehot(id) : 0.
  - rsp_data = add_out, passed straight through.
- Responses have no backpressure. Requesters must accept the result in the pulse cycle; a missed pulse loses the result.
- inflight counting:
  - +1 on a handshake; −1 when any rsp_valid is set; unchanged when both occur in the same cycle.
  - The counter never exceeds ADD_LAT+1, which the pipeline depth guarantees. The bench asserts this bound.
- Requester i must hold req_a, req_b and req_sub stable while req_valid[i]=1 and req_ready[i]=0. Deasserting valid without a handshake is permitted.

## Timing
- A handshake in cycle t makes add_a and add_b valid in cycle t+1.
- The result appears on rsp_valid/rsp_data in cycle t+1+ADD_LAT, which is t+4 at the default.
- Throughput is one operation per cycle, sustained across requesters. A single requester held valid is granted every cycle when alone.
- Reset values: req_ready=0 while rst is asserted, rr_ptr=0, add_a=0, add_b=0, all tags invalid, rsp_valid=0, inflight=0, busy=0.
- Reset asserted mid-operation: all in-flight tags are dropped immediately and no rsp_valid pulse occurs for them. The adder is reset from the same source through an inverter at the top level.
- Simultaneous handshake and response in one cycle: both are processed and inflight is unchanged.
- All requesters valid: grants rotate 0,1,2,3,0,… with exactly one grant per cycle.

## Configuration
- `FADD_ARB_SUB_EN` defined:
  - Adds the req_sub input.
  - On a handshake with req_sub[g]=1, add_b <= {~req_b[g][W-1], req_b[g][W-2:0]}, i.e. the sign of B is flipped, so the adder computes A−B.
- `FADD_ARB_SUB_EN` undefined:
  - The port is absent and add_b is always req_b[g] unmodified.

## Structure
- The shared package `fadd_pkg` holds:
  - E_BIT, F_BIT, W and ADD_LAT constants.
  - The `fadd_word_t` typedef.
  - The `fadd_tag_t` struct {valid, id}.
- One sub-module, `rr_arbiter` (N-way round-robin grant with pointer update), is natural and is reused by future shared-resource blocks.
- The tag pipeline and the inflight counter stay in the top module.

## Test plan
- Single request: requester 2 issues A=0x3F800000 (1.0), B=0x40000000 (2.0) in cycle 5.
  - Required: rsp_valid=4'b0100 in cycle 9 only, rsp_data=0x40400000 (3.0).
- All four requesters valid continuously for 8 cycles, with rr_ptr=0 at start.
  - Required: grants 0,1,2,3,0,1,2,3; responses return in the same order 4 cycles later.
  - Required: inflight peaks at 4 and returns to 0.
- Requesters 1 and 3 valid with rr_ptr=2.
  - Required: 3 is granted first, then 1 (wrap-around); rr_ptr ends at 2.
- Reset asserted for 1 cycle while 3 operations are in flight.
  - Required: no rsp_valid pulse for any of them; busy=0 and inflight=0 in the cycle after reset.
- With FADD_ARB_SUB_EN: A=0x40A00000 (5.0), B=0x40400000 (3.0), req_sub=1.
  - Required: add_b=0xC0400000; rsp_data=0x40000000 (2.0).
- Handshake and result in the same cycle during a back-to-back stream.
  - Required: inflight stays constant at 4 throughout the steady state.

Source files
------------

// File: rtl/float_adder_arbiter_pkg.sv
// Shared constants and types for the float adder arbitration slice.
// Optional feature macro used by users of this package: FADD_ARB_SUB_EN.
package fadd_pkg;

  localparam int E_BIT   = 8;
  localparam int F_BIT   = 23;
  localparam int W       = E_BIT + F_BIT + 1;
  localparam int ADD_LAT = 3;

  // Tags are sized for the largest supported requester count.
  localparam int MAX_REQ = 16;
  localparam int ID_W    = $clog2(MAX_REQ);
  localparam int INFL_W  = $clog2(ADD_LAT + 2);

  typedef logic [W-1:0] fadd_word_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } fadd_tag_t;

  // Flip the sign bit so that an adder computing A+B yields A-B.
  function automatic fadd_word_t fadd_negate(fadd_word_t w);
    return {~w[W-1], w[W-2:0]};
  endfunction

endpackage

// File: rtl/float_adder_arbiter_if.sv
// Bundle between compute requesters, the shared adder and the arbiter.
// FADD_ARB_SUB_EN adds the per-requester subtract request.
interface float_adder_arbiter_if #(
  parameter int N_REQ = 4
) ();
  import fadd_pkg::*;

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
`ifdef FADD_ARB_SUB_EN
  logic [N_REQ-1:0]   req_sub;
`endif
  fadd_word_t         add_a;
  fadd_word_t         add_b;
  fadd_word_t         add_out;
  logic [N_REQ-1:0]   rsp_valid;
  fadd_word_t         rsp_data;
  logic [INFL_W-1:0]  inflight;
  logic               busy;

`ifdef FADD_ARB_SUB_EN
  modport master (
    output req_valid, req_a, req_b, req_sub, add_out,
    input  req_ready, add_a, add_b, rsp_valid, rsp_data, inflight, busy
  );
  modport slave (
    input  req_valid, req_a, req_b, req_sub, add_out,
    output req_ready, add_a, add_b, rsp_valid, rsp_data, inflight, busy
  );
`else
  modport master (
    output req_valid, req_a, req_b, add_out,
    input  req_ready, add_a, add_b, rsp_valid, rsp_data, inflight, busy
  );
  modport slave (
    input  req_valid, req_a, req_b, add_out,
    output req_ready, add_a, add_b, rsp_valid, rsp_data, inflight, busy
  );
`endif

endinterface

// File: rtl/float_adder_arbiter_rr_arbiter.sv
// N-way round-robin grant with pointer update, reusable for any shared resource.
// Grants are suppressed while reset is asserted.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_id,
  output logic          grant_valid
);

  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] rr_ptr_d;
  logic [PW:0]   idx;

  // Pick the first request at or after the pointer, wrapping, and advance past the winner.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!grant_valid && req[idx[PW-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = idx[PW-1:0];
      end
    end
    if (rst) grant_valid = 1'b0;
    if (grant_valid) begin
      grant[grant_id] = 1'b1;
      rr_ptr_d = (grant_id == PW'(N-1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Priority pointer register; holds when nobody is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/float_adder_arbiter.sv
// Shares one pipelined float adder between N_REQ requesters and routes each
// result back to its owner via a tag pipeline matched to the adder depth.
// Optional macro FADD_ARB_SUB_EN: per-requester subtract by flipping B's sign.
module float_adder_arbiter
  import fadd_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input logic                  clk,
  input logic                  rst,
  float_adder_arbiter_if.slave bus
);

  localparam int PW = $clog2(N_REQ);

  logic [N_REQ-1:0]  grant;
  logic [PW-1:0]     grant_id;
  logic              grant_valid;
  fadd_word_t        sel_a;
  fadd_word_t        sel_b;
  fadd_word_t        add_a_q, add_a_d;
  fadd_word_t        add_b_q, add_b_d;
  fadd_tag_t         tag_q [ADD_LAT+1];
  fadd_tag_t         tag_d [ADD_LAT+1];
  logic [N_REQ-1:0]  rsp_valid;
  logic [INFL_W-1:0] inflight_q, inflight_d;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.req_valid),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign bus.req_ready = grant;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = bus.add_out;
  assign bus.inflight  = inflight_q;
  assign bus.busy      = (inflight_q != '0);

  // Mux the winner's operands, optionally negate B, and launch an issue or bubble tag.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == PW'(i)) begin
        sel_a = bus.req_a[i*W +: W];
        sel_b = bus.req_b[i*W +: W];
      end
    end
`ifdef FADD_ARB_SUB_EN
    if (bus.req_sub[grant_id]) sel_b = fadd_negate(sel_b);
`endif
    add_a_d        = add_a_q;
    add_b_d        = add_b_q;
    tag_d[0]       = '0;
    if (grant_valid) begin
      add_a_d        = sel_a;
      add_b_d        = sel_b;
      tag_d[0].valid = 1'b1;
      tag_d[0].id    = ID_W'(grant_id);
    end
    for (int i = 1; i <= ADD_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  // The oldest tag lines up with add_out and selects the requester to pulse.
  always_comb begin
    rsp_valid = '0;
    if (tag_q[ADD_LAT].valid) rsp_valid[tag_q[ADD_LAT].id[PW-1:0]] = 1'b1;
  end

  // Issues add one, returning results remove one; both together cancel.
  always_comb begin
    inflight_d = inflight_q;
    case ({grant_valid, tag_q[ADD_LAT].valid})
      2'b10:   inflight_d = inflight_q + INFL_W'(1);
      2'b01:   inflight_d = inflight_q - INFL_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Operand, tag and occupancy registers; reset drops every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a_q    <= '0;
      add_b_q    <= '0;
      inflight_q <= '0;
      for (int i = 0; i <= ADD_LAT; i++) tag_q[i] <= '0;
    end else begin
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      inflight_q <= inflight_d;
      for (int i = 0; i <= ADD_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule
